serial_negate_multi: RTL and testbench
======================================

Name: serial_negate_multi

Overview:
- Parametrised successor to the single-bit serial two's-complement inverter.
- Processes NCH independent bit-serial channels in lockstep. Each word is WIDTH bits long, sent LSB first.
- Per channel and per word, the block either negates (two's complement) or passes the word through.
- Adds word framing, a valid qualifier, a resync input, a last-bit marker and overflow detection. Sits between a serial source and the downstream serial arithmetic chain.

Parameters:
- WIDTH, 8: bits per serial word; legal range 1 to 64.
- NCH, 1: number of parallel serial channels; legal range 1 to 32.

Ports:
- t_clk  input  1  clock; all state changes on its rising edge.
- r_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  the current bit on in_bit is accepted this cycle.
- in_sync  input  1  when high with in_valid, this bit is bit 0 of a new word.
- in_bit  input  NCH  one serial data bit per channel, LSB first.
- neg_en  input  NCH  per channel: 1 = negate, 0 = pass; sampled on bit 0 only.
- out_valid  output  1  out_bit carries a result bit this cycle.
- out_bit  output  NCH  one serial result bit per channel.
- out_last  output  1  high with out_valid on bit WIDTH-1 of a word.
- ovf  output  NCH  overflow pulse per channel, meaningful only with out_last.

Behaviour:
- Reset: when r_n goes low, at once and without waiting for a clock edge:
  - out_valid, out_bit, out_last and ovf go to 0.
  - The bit counter (idx) goes to 0.
  - All seen[] flags and held neg_en flags (mode[]) go to 0.
- Reset mid-word discards that word. The next accepted bit is bit 0.
- idx is a counter of width max(1, clog2(WIDTH)).
- Bit acceptance: a bit is accepted when in_valid=1 on a rising edge.
  - Bit index k = 0 if in_sync=1, otherwise k = idx.
- Per channel c, on an accepted bit b:
  - Effective mode m = neg_en[c] if k==0, otherwise mode[c]. At k==0, mode[c] is loaded with neg_en[c].
  - Effective seen s = 0 if k==0, otherwise seen[c].
  - out_bit[c] is registered as b XOR (m AND s).
  - seen[c] is updated to s OR b.
- Counter and framing on an accepted bit:
  - If k == WIDTH-1: out_last=1, idx returns to 0, all seen[] clear.
  - Otherwise: out_last=0, idx = k+1.
  - out_valid=1.
- Overflow: at k == WIDTH-1, ovf[c] = m AND b AND NOT s.
  - This is the most-negative input (only the MSB set); its negation is not representable.
  - In that case out_bit equals the input bits.
  - ovf is 0 in every other cycle.
- Latency: one cycle. The result for the bit accepted at edge n is visible after edge n and stays valid until edge n+1.
- Cycles with in_valid=0:
  - out_valid, out_last and ovf go to 0.
  - out_bit, idx, seen[] and mode[] hold.
  - Gaps of any length inside a word are legal.
- Boundary cases:
  - in_sync on the last bit of a word: the bit is treated as bit 0 of a new word and the partial word is abandoned. No out_last is produced for the abandoned word.
  - in_sync with in_valid=0 is ignored.
  - A zero word negates to zero, with ovf=0.
  - neg_en changes mid-word have no effect until the next bit 0.
  - WIDTH=1: every bit is both bit 0 and the last bit. Input 1 with negate gives out_bit=1 and ovf=1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (WIDTH=4, NCH=2 unless noted):
1. Negate five on channel 0:
   - Stimulus: ch0 bits 1,0,1,0 (value 5), neg_en=01, in_sync on the first bit, in_valid every cycle.
   - Required: ch0 out 1,1,0,1 (value 11 = -5); ch1 (pass mode) echoes its input; out_last on the 4th output; ovf=00.
2. Negate the most-negative value:
   - Stimulus: ch0 bits 0,0,0,1 (value -8), negate.
   - Required: out 0,0,0,1; ovf[0]=1 with out_last only.
   - Same stimulus with pass mode: ovf=0.
3. Back-to-back words with gaps:
   - Stimulus: ch1 words 6 then 0, negate, in_valid low for 3 cycles inside each word.
   - Required: ch1 out 0,1,0,1 then 0,0,0,0; out_valid low and out_bit held during the gaps; exactly two out_last pulses.
4. Mode change mid-word:
   - Stimulus: neg_en[0] goes from 1 to 0 at bit 2 of word 3 (bits 1,1,0,0).
   - Required: out 1,0,1,1 (negation retained for the whole word); pass mode takes effect from the next word.
5. Resync and reset mid-word:
   - Stimulus: in_sync after 2 bits, then a full word 2.
   - Required: the next 4 outputs are 0,1,1,1 with out_last on the 4th.
   - Stimulus: assert r_n=0 between clock edges mid-word.
   - Required: all outputs go to 0 immediately; after release, the first accepted bit is treated as bit 0.
6. WIDTH=1, NCH=3:
   - Stimulus: bits 101 with negate on all channels.
   - Required: out_bit=101, out_last=1 every valid cycle, ovf=101.

Source files
------------

// File: rtl/serial_negate_multi.sv
// serial_negate_multi: NCH lockstep bit-serial channels, LSB first,
// each word negated (two's complement) or passed per channel.
//
// Ports:
//   t_clk     : clock, rising edge
//   r_n       : async active-low reset
//   in_valid  : accept in_bit this cycle
//   in_sync   : with in_valid, this bit is bit 0 of a new word
//   in_bit    : [NCH] serial data in
//   neg_en    : [NCH] 1=negate, 0=pass; sampled on bit 0
//   out_valid : out_bit holds a result bit
//   out_bit   : [NCH] serial result out
//   out_last  : with out_valid on bit WIDTH-1
//   ovf       : [NCH] most-negative word negated, with out_last
module serial_negate_multi #(
  parameter int WIDTH = 8,
  parameter int NCH   = 1
) (
  input  logic           t_clk,
  input  logic           r_n,
  input  logic           in_valid,
  input  logic           in_sync,
  input  logic [NCH-1:0] in_bit,
  input  logic [NCH-1:0] neg_en,
  output logic           out_valid,
  output logic [NCH-1:0] out_bit,
  output logic           out_last,
  output logic [NCH-1:0] ovf
);

  localparam int IW =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(WIDTH - 1);

  logic [IW-1:0]  r_idx;
  logic [NCH-1:0] r_seen;
  logic [NCH-1:0] r_mode;

  logic [IW-1:0]  w_k;
  logic [IW-1:0]  w_idx_nxt;
  logic           w_first;
  logic           w_last;
  logic [NCH-1:0] w_m;
  logic [NCH-1:0] w_s;
  logic [NCH-1:0] w_obit;
  logic [NCH-1:0] w_ovf;
  logic [NCH-1:0] w_seen_nxt;

  // Negation = copy bits up to and including
  // the first 1, then invert; seen marks that 1.
  always_comb begin
    w_k        = in_sync ? '0 : r_idx;
    w_first    = (w_k == '0);
    w_last     = (w_k == LAST);
    w_m        = w_first ? neg_en : r_mode;
    w_s        = w_first ? '0 : r_seen;
    w_obit     = in_bit ^ (w_m & w_s);
    w_ovf      = '0;
    w_idx_nxt  = w_k + IW'(1);
    w_seen_nxt = w_s | in_bit;
    if (w_last) begin
      // only MSB set: -x is not representable
      w_ovf      = w_m & in_bit & ~w_s;
      w_idx_nxt  = '0;
      w_seen_nxt = '0;
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      out_valid <= 1'b0;
      out_bit   <= '0;
      out_last  <= 1'b0;
      ovf       <= '0;
      r_idx     <= '0;
      r_seen    <= '0;
      r_mode    <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_bit   <= w_obit;
      out_last  <= w_last;
      ovf       <= w_ovf;
      r_idx     <= w_idx_nxt;
      r_seen    <= w_seen_nxt;
      if (w_first) begin
        r_mode <= neg_en;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= '0;
    end
  end

endmodule

// File: tb/tb_serial_negate_multi.sv
// tb_serial_negate_multi: scoreboard bench for
// serial_negate_multi (WIDTH=4/NCH=2 and WIDTH=1/NCH=3).
module tb_serial_negate_multi;

  logic t_clk = 1'b0;
  logic r_n;
  always #5 t_clk = ~t_clk;

  logic       a_iv, a_sy, a_ov, a_ol;
  logic [1:0] a_ib, a_ne, a_ob, a_of;
  logic       b_iv, b_sy, b_ov, b_ol;
  logic [2:0] b_ib, b_ne, b_ob, b_of;

  serial_negate_multi #(.WIDTH(4), .NCH(2)) u_a (
    .t_clk(t_clk), .r_n(r_n),
    .in_valid(a_iv), .in_sync(a_sy),
    .in_bit(a_ib), .neg_en(a_ne),
    .out_valid(a_ov), .out_bit(a_ob),
    .out_last(a_ol), .ovf(a_of)
  );

  serial_negate_multi #(.WIDTH(1), .NCH(3)) u_b (
    .t_clk(t_clk), .r_n(r_n),
    .in_valid(b_iv), .in_sync(b_sy),
    .in_bit(b_ib), .neg_en(b_ne),
    .out_valid(b_ov), .out_bit(b_ob),
    .out_last(b_ol), .ovf(b_of)
  );

  typedef struct {
    logic [31:0] bits;
    logic        lst;
    logic [31:0] ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int ncmp = 0;
  int nbad = 0;

  // reference: per unit, the word prefix seen so
  // far as an integer; result bit k is bit k of
  // the arithmetic negation of that prefix.
  int              m_idx[2];
  longint unsigned m_pre[2][32];
  bit              m_md[2][32];
  logic [31:0]     m_hold[2];

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u]  = 0;
      m_hold[u] = '0;
      for (int c = 0; c < 32; c++) begin
        m_pre[u][c] = 0;
        m_md[u][c]  = 0;
      end
    end
  endtask

  task automatic step(int u, int w, int n,
                      bit sy,
                      logic [31:0] b,
                      logic [31:0] ne,
                      output exp_t e);
    int k;
    longint unsigned nv;
    k = sy ? 0 : m_idx[u];
    e.bits = '0;
    e.ovf  = '0;
    e.lst  = (k == w - 1);
    for (int c = 0; c < n; c++) begin
      if (k == 0) begin
        m_pre[u][c] = 0;
        m_md[u][c]  = ne[c];
      end
      if (b[c])
        m_pre[u][c] |= (64'd1 << k);
      if (m_md[u][c]) begin
        nv = ~m_pre[u][c] + 64'd1;
        e.bits[c] = nv[k];
      end else begin
        e.bits[c] = b[c];
      end
      if (e.lst && m_md[u][c] &&
          m_pre[u][c] == (64'd1 << (w - 1)))
        e.ovf[c] = 1'b1;
    end
    m_idx[u] = e.lst ? 0 : k + 1;
  endtask

  task automatic drv_a(bit v, bit s,
                       logic [1:0] b,
                       logic [1:0] ne);
    exp_t e;
    @(negedge t_clk);
    a_iv = v; a_sy = s;
    a_ib = b; a_ne = ne;
    b_iv = 1'b0;
    if (v) begin
      step(0, 4, 2, s, 32'(b), 32'(ne), e);
      qa.push_back(e);
    end
  endtask

  task automatic drv_b(bit v, bit s,
                       logic [2:0] b,
                       logic [2:0] ne);
    exp_t e;
    @(negedge t_clk);
    b_iv = v; b_sy = s;
    b_ib = b; b_ne = ne;
    a_iv = 1'b0;
    if (v) begin
      step(1, 1, 3, s, 32'(b), 32'(ne), e);
      qb.push_back(e);
    end
  endtask

  task automatic word_a(logic [3:0] x0,
                        logic [3:0] x1,
                        logic [1:0] ne,
                        bit sy);
    for (int i = 0; i < 4; i++)
      drv_a(1'b1, sy && i == 0,
            {x1[i], x0[i]}, ne);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_av"}, 32'(a_ov), 0);
    chk({nm, "_ab"}, 32'(a_ob), 0);
    chk({nm, "_al"}, 32'(a_ol), 0);
    chk({nm, "_ao"}, 32'(a_of), 0);
    chk({nm, "_bv"}, 32'(b_ov), 0);
    chk({nm, "_bb"}, 32'(b_ob), 0);
    chk({nm, "_bl"}, 32'(b_ol), 0);
    chk({nm, "_bo"}, 32'(b_of), 0);
  endtask

  task automatic reset_mid();
    @(negedge t_clk);
    a_iv = 1'b0; b_iv = 1'b0;
    #2 r_n = 1'b0;
    #1 chk_zero("rst_mid");
    mdl_reset();
    @(negedge t_clk);
    r_n = 1'b1;
  endtask

  always @(posedge t_clk) begin
    exp_t e;
    #1;
    if (r_n) begin
      if (a_ov) begin
        if (qa.size() == 0) begin
          chk("A_extra_valid", 32'(a_ov), 0);
        end else begin
          e = qa.pop_front();
          chk("A_bit", 32'(a_ob), e.bits);
          chk("A_last", 32'(a_ol), 32'(e.lst));
          chk("A_ovf", 32'(a_of), e.ovf);
          m_hold[0] = e.bits;
        end
      end else begin
        chk("A_idle_last", 32'(a_ol), 0);
        chk("A_idle_ovf", 32'(a_of), 0);
        chk("A_hold", 32'(a_ob), m_hold[0]);
      end
      if (b_ov) begin
        if (qb.size() == 0) begin
          chk("B_extra_valid", 32'(b_ov), 0);
        end else begin
          e = qb.pop_front();
          chk("B_bit", 32'(b_ob), e.bits);
          chk("B_last", 32'(b_ol), 32'(e.lst));
          chk("B_ovf", 32'(b_of), e.ovf);
          m_hold[1] = e.bits;
        end
      end else begin
        chk("B_idle_last", 32'(b_ol), 0);
        chk("B_idle_ovf", 32'(b_of), 0);
        chk("B_hold", 32'(b_ob), m_hold[1]);
      end
    end
  end

  initial begin
    r_n  = 1'b1;
    a_iv = 0; a_sy = 0; a_ib = 0; a_ne = 0;
    b_iv = 0; b_sy = 0; b_ib = 0; b_ne = 0;
    mdl_reset();
    #1 r_n = 1'b0;
    #3 chk_zero("por");
    repeat (2) @(negedge t_clk);
    r_n = 1'b1;

    // negate 5 on ch0, ch1 passes
    word_a(4'd5, 4'd9, 2'b01, 1'b1);
    // most-negative, negate then pass
    word_a(4'b1000, 4'b1000, 2'b11, 1'b1);
    word_a(4'b1000, 4'd3, 2'b00, 1'b1);
    // zero word negated
    word_a(4'd0, 4'd0, 2'b11, 1'b1);

    // ch1 words 6 then 0, gaps inside
    for (int w = 0; w < 2; w++) begin
      logic [3:0] x;
      x = (w == 0) ? 4'd6 : 4'd0;
      for (int i = 0; i < 4; i++) begin
        drv_a(1'b1, i == 0,
              {x[i], 1'($urandom)}, 2'b10);
        if (i == 1)
          repeat (3)
            drv_a(1'b0, 1'($urandom),
                  2'($urandom), 2'($urandom));
      end
    end

    // neg_en drops mid-word
    for (int i = 0; i < 4; i++) begin
      logic [3:0] x;
      x = 4'd3;
      drv_a(1'b1, i == 0, {1'b0, x[i]},
            (i < 2) ? 2'b01 : 2'b00);
    end
    word_a(4'd3, 4'd1, 2'b00, 1'b0);

    // resync after 2 bits, then word 2
    drv_a(1'b1, 1'b1, 2'b11, 2'b11);
    drv_a(1'b1, 1'b0, 2'b01, 2'b11);
    word_a(4'd2, 4'd7, 2'b01, 1'b1);

    // reset mid-word, then no sync
    drv_a(1'b1, 1'b1, 2'b10, 2'b11);
    drv_a(1'b1, 1'b0, 2'b11, 2'b11);
    reset_mid();
    word_a(4'd1, 4'd12, 2'b11, 1'b0);

    // random traffic
    repeat (300)
      drv_a($urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0,
            2'($urandom), 2'($urandom));

    // WIDTH=1, NCH=3
    repeat (3) drv_b(1'b1, 1'b0, 3'b101, 3'b111);
    drv_b(1'b0, 1'b1, 3'b111, 3'b111);
    drv_b(1'b1, 1'b1, 3'b110, 3'b011);
    repeat (100)
      drv_b($urandom_range(0, 2) != 0,
            1'($urandom),
            3'($urandom), 3'($urandom));

    repeat (3) drv_a(1'b0, 1'b0, 2'b00, 2'b00);
    chk("A_drain", qa.size(), 0);
    chk("B_drain", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
